// File: rtl/seg_pkg.sv
// Shared seven-segment pattern table (active-low, bit 6 = g ... bit 0 = a).
// Used by both the display encoder and the frame decoder so they agree on glyphs.
package seg_pkg;

    localparam int unsigned SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    // Nibble to glyph, for the encoder side of the loopback.
    function automatic logic [SEG_W-1:0] seg_encode(input logic [3:0] v);
        logic [SEG_W-1:0] s;
        s = SEG_BLANK;
        case (v)
            4'h0: s = SEG_0;
            4'h1: s = SEG_1;
            4'h2: s = SEG_2;
            4'h3: s = SEG_3;
            4'h4: s = SEG_4;
            4'h5: s = SEG_5;
            4'h6: s = SEG_6;
            4'h7: s = SEG_7;
            4'h8: s = SEG_8;
            4'h9: s = SEG_9;
            4'hA: s = SEG_A;
            4'hB: s = SEG_B;
            4'hC: s = SEG_C;
            4'hD: s = SEG_D;
            4'hE: s = SEG_E;
            4'hF: s = SEG_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg2bin.sv
// Combinational seven-segment glyph to nibble decoder.
// o_hit is low for any pattern that is not one of the sixteen hex glyphs.
module seg2bin
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0] i_seg,
    output logic [3:0]       o_bin,
    output logic             o_hit
);

    // Table lookup; unknown glyphs (including blank) decode to 0 with o_hit low.
    always_comb begin
        o_bin = 4'h0;
        o_hit = 1'b1;
        case (i_seg)
            SEG_0:   o_bin = 4'h0;
            SEG_1:   o_bin = 4'h1;
            SEG_2:   o_bin = 4'h2;
            SEG_3:   o_bin = 4'h3;
            SEG_4:   o_bin = 4'h4;
            SEG_5:   o_bin = 4'h5;
            SEG_6:   o_bin = 4'h6;
            SEG_7:   o_bin = 4'h7;
            SEG_8:   o_bin = 4'h8;
            SEG_9:   o_bin = 4'h9;
            SEG_A:   o_bin = 4'hA;
            SEG_B:   o_bin = 4'hB;
            SEG_C:   o_bin = 4'hC;
            SEG_D:   o_bin = 4'hD;
            SEG_E:   o_bin = 4'hE;
            SEG_F:   o_bin = 4'hF;
            default: o_hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_frame_decoder.sv
// Observes a multiplexed active-low seven-segment bus and recovers the displayed
// hex word. Each digit dwell is captured once after STABLE_CYCLES identical samples.
module seg_frame_decoder
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 8,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [SEG_W-1:0]        i_seg,
    input  logic [NUM_DIGITS-1:0]   i_an,
    output logic [4*NUM_DIGITS-1:0] o_word,
    output logic                    o_valid,
    output logic                    o_err,
    output logic [NUM_DIGITS-1:0]   o_mask
);

    localparam int unsigned          WW  = 4 * NUM_DIGITS;
    localparam int unsigned          CW  = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]        CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

    logic [NUM_DIGITS-1:0] an_q;
    logic [SEG_W-1:0]      seg_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  cap_q, cap_d;
    logic [WW-1:0]         buf_q, buf_d;
    logic [NUM_DIGITS-1:0] mask_q, mask_d;
    logic                  ferr_q, ferr_d;
    logic [WW-1:0]         word_q, word_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    logic [NUM_DIGITS-1:0] sel, in_sel;
    logic                  sel_onehot, in_onehot;
    logic                  pair_changed;
    logic                  capture;
    logic [WW-1:0]         nib_sel;
    logic [3:0]            bin;
    logic                  hit;

    // Strobes are active-low; invert to get a one-hot digit select.
    assign sel        = ~an_q;
    assign in_sel     = ~i_an;
    assign sel_onehot = (sel != '0) && ((sel & (sel - ONE)) == '0);
    assign in_onehot  = (in_sel != '0) && ((in_sel & (in_sel - ONE)) == '0);

    // Compared against the incoming pair so cnt reads 1 on the first registered cycle.
    assign pair_changed = (i_an != an_q) || (i_seg != seg_q);

    assign capture = sel_onehot && (cnt_q == CNT_MAX) && !cap_q;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
        assign nib_sel[4*g +: 4] = {4{sel[g]}};
    end

    seg2bin u_seg2bin (
        .i_seg (seg_q),
        .o_bin (bin),
        .o_hit (hit)
    );

    // Next-state: stability window, capture into the frame buffer, frame completion.
    always_comb begin
        logic [NUM_DIGITS-1:0] mask_new;
        logic [WW-1:0]         buf_new;
        logic                  ferr_new;

        cnt_d   = cnt_q;
        cap_d   = cap_q;
        word_d  = word_q;
        err_d   = err_q;
        valid_d = 1'b0;

        if (!in_onehot) begin
            cnt_d = '0;
            cap_d = 1'b0;
        end else if (pair_changed) begin
            cnt_d = CW'(1);
            cap_d = 1'b0;
        end else begin
            if (cnt_q < CNT_MAX) begin
                cnt_d = cnt_q + CW'(1);
            end
            cap_d = cap_q | capture;
        end

        mask_new = mask_q;
        buf_new  = buf_q;
        ferr_new = ferr_q;
        if (capture) begin
            mask_new = mask_q | sel;
            buf_new  = (buf_q & ~nib_sel) | ({NUM_DIGITS{bin}} & nib_sel);
            ferr_new = ferr_q | !hit;
        end

        buf_d  = buf_new;
        mask_d = mask_new;
        ferr_d = ferr_new;
        if (capture && (mask_new == '1)) begin
            word_d  = buf_new;
            err_d   = ferr_new;
            valid_d = 1'b1;
            mask_d  = '0;
            ferr_d  = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            an_q    <= '1;
            seg_q   <= SEG_BLANK;
            cnt_q   <= '0;
            cap_q   <= 1'b0;
            buf_q   <= '0;
            mask_q  <= '0;
            ferr_q  <= 1'b0;
            word_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            an_q    <= i_an;
            seg_q   <= i_seg;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            buf_q   <= buf_d;
            mask_q  <= mask_d;
            ferr_q  <= ferr_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign o_word  = word_q;
    assign o_valid = valid_q;
    assign o_err   = err_q;
    assign o_mask  = mask_q;

endmodule

// File: tb/tb_seg_frame_decoder.sv
// Bench for seg_frame_decoder: frame table, directed corner sequences and random
// bus activity, all checked every cycle against a sample-history reference model.
module tb_seg_frame_decoder;

    localparam int ND = 8;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    seg;
    logic [ND-1:0] an;
    logic [4*ND-1:0] o_word;
    logic          o_valid;
    logic          o_err;
    logic [ND-1:0] o_mask;

    always #5 clk = ~clk;

    seg_frame_decoder #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_seg   (seg),
        .i_an    (an),
        .o_word  (o_word),
        .o_valid (o_valid),
        .o_err   (o_err),
        .o_mask  (o_mask)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference model state
    logic [ND+6:0]   hist [$];
    logic            pend;
    int              pend_idx;
    logic [6:0]      pend_seg;
    logic [3:0]      m_dig [ND];
    logic [ND-1:0]   m_mask;
    logic            m_ferr;
    logic [4*ND-1:0] m_word;
    logic            m_err;
    logic            m_valid;

    // Observers
    int              valid_cnt;
    logic [4*ND-1:0] last_word;
    logic            last_err;
    int              rise2;
    logic            prev_m2;

    typedef struct {
        logic [31:0] word;
        int          bad_digit;
        logic [6:0]  bad_pat;
        logic [31:0] exp_word;
        logic        exp_err;
    } frame_vec_t;

    frame_vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void decode(input logic [6:0] s, output logic [3:0] nib, output logic ok);
        nib = 4'h0;
        ok  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (hex_tab[k] == s) begin
                nib = 4'(k);
                ok  = 1'b1;
            end
        end
    endfunction

    function automatic int onehot_low_idx(input logic [ND-1:0] a);
        int zeros = 0;
        int idx = -1;
        for (int i = 0; i < ND; i++) begin
            if (!a[i]) begin
                zeros++;
                idx = i;
            end
        end
        return (zeros == 1) ? idx : -1;
    endfunction

    // Model: a dwell is captured when its run of identical samples reaches SC;
    // the result becomes visible one edge later.
    task automatic model_edge(input logic r, input logic [ND-1:0] a, input logic [6:0] s);
        logic [3:0] nib;
        logic       ok;
        logic       same;
        int         n;
        if (r) begin
            hist.delete();
            pend    = 1'b0;
            m_mask  = '0;
            m_ferr  = 1'b0;
            m_word  = '0;
            m_err   = 1'b0;
            m_valid = 1'b0;
            return;
        end
        m_valid = 1'b0;
        if (pend) begin
            decode(pend_seg, nib, ok);
            m_dig[pend_idx]  = nib;
            m_mask[pend_idx] = 1'b1;
            if (!ok) m_ferr = 1'b1;
            if (&m_mask) begin
                for (int i = 0; i < ND; i++) m_word[4*i +: 4] = m_dig[i];
                m_err   = m_ferr;
                m_valid = 1'b1;
                m_mask  = '0;
                m_ferr  = 1'b0;
            end
        end
        pend = 1'b0;
        hist.push_back({a, s});
        if (hist.size() > SC + 1) void'(hist.pop_front());
        n = hist.size();
        if (n >= SC && onehot_low_idx(a) >= 0) begin
            same = 1'b1;
            for (int i = n - SC; i < n; i++) if (hist[i] != hist[n-1]) same = 1'b0;
            if (same && (n == SC || hist[0] != hist[n-1])) begin
                pend     = 1'b1;
                pend_idx = onehot_low_idx(a);
                pend_seg = s;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic [ND-1:0] a, input logic [6:0] s);
        rst = r;
        an  = a;
        seg = s;
        @(posedge clk);
        model_edge(r, a, s);
        #1;
        chk("mask",  64'(o_mask),  64'(m_mask));
        chk("valid", 64'(o_valid), 64'(m_valid));
        chk("word",  64'(o_word),  64'(m_word));
        chk("err",   64'(o_err),   64'(m_err));
        if (o_valid) begin
            valid_cnt++;
            last_word = o_word;
            last_err  = o_err;
        end
        if (o_mask[2] && !prev_m2) rise2++;
        prev_m2 = o_mask[2];
    endtask

    task automatic show(input int d, input logic [6:0] s, input int n);
        logic [ND-1:0] a;
        a    = '1;
        a[d] = 1'b0;
        repeat (n) cyc(1'b0, a, s);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, '1, 7'b1111111);
    endtask

    task automatic scan(input logic [31:0] w, input int bad, input logic [6:0] bp, input int dw);
        for (int d = 0; d < ND; d++) begin
            show(d, (d == bad) ? bp : hex_tab[w[4*d +: 4]], dw);
        end
        idle(2);
    endtask

    initial begin
        logic [31:0] w;
        logic [ND-1:0] a;
        int r, d, dw;
        logic [6:0] p;

        vecs[0] = '{32'h12345678, -1, 7'h7F,       32'h12345678, 1'b0};
        vecs[1] = '{32'h12345678,  3, 7'b1111111,  32'h12340678, 1'b1};
        vecs[2] = '{32'hDEADBEEF, -1, 7'h7F,       32'hDEADBEEF, 1'b0};
        vecs[3] = '{32'hCAFE019B,  0, 7'b0101010,  32'hCAFE0190, 1'b1};
        vecs[4] = '{32'h0F1E2D3C, -1, 7'h7F,       32'h0F1E2D3C, 1'b0};

        pend = 1'b0; m_mask = '0; m_ferr = 1'b0; m_word = '0; m_err = 1'b0; m_valid = 1'b0;
        for (int i = 0; i < ND; i++) m_dig[i] = 4'h0;
        valid_cnt = 0; last_word = '0; last_err = 1'b0; rise2 = 0; prev_m2 = 1'b0;

        // Reset state
        cyc(1'b1, '1, 7'b1111111);
        cyc(1'b1, '1, 7'b1111111);
        chk("rst_word",  64'(o_word),  64'h0);
        chk("rst_valid", 64'(o_valid), 64'h0);
        chk("rst_err",   64'(o_err),   64'h0);
        chk("rst_mask",  64'(o_mask),  64'h0);
        idle(3);

        // Frame table, 6-cycle dwells
        for (int v = 0; v < 5; v++) begin
            valid_cnt = 0;
            scan(vecs[v].word, vecs[v].bad_digit, vecs[v].bad_pat, 6);
            chk("tbl_valid_cnt", 64'(valid_cnt), 64'd1);
            chk("tbl_word",      64'(last_word), 64'(vecs[v].exp_word));
            chk("tbl_err",       64'(last_err),  64'(vecs[v].exp_err));
        end

        // Short dwell on digit 5 is ignored until a full-length dwell
        valid_cnt = 0;
        w = 32'h12345678;
        for (int i = 0; i < ND; i++) if (i != 5) show(i, hex_tab[w[4*i +: 4]], 6);
        show(5, hex_tab[w[23:20]], 3);
        idle(2);
        chk("short_mask5",   64'(o_mask[5]), 64'h0);
        chk("short_novalid", 64'(valid_cnt), 64'd0);
        show(5, hex_tab[w[23:20]], 4);
        idle(2);
        chk("short_valid_cnt", 64'(valid_cnt), 64'd1);
        chk("short_word",      64'(last_word), 64'h12345678);

        // Long hold on digit 2 captures once
        valid_cnt = 0;
        rise2 = 0;
        show(2, hex_tab[w[11:8]], 100);
        chk("hold_rise2", 64'(rise2), 64'd1);
        for (int i = 0; i < ND; i++) if (i != 2) show(i, hex_tab[w[4*i +: 4]], 6);
        idle(2);
        chk("hold_valid_cnt", 64'(valid_cnt), 64'd1);
        chk("hold_word",      64'(last_word), 64'h12345678);
        chk("hold_rise2_end", 64'(rise2),     64'd1);

        // Blanking and multi-low strobes do not capture
        show(0, hex_tab[1], 6);
        show(1, hex_tab[2], 6);
        show(3, hex_tab[4], 6);
        idle(10);
        chk("blank_mask", 64'(o_mask), 64'h0B);
        repeat (10) cyc(1'b0, 8'b1110_0111, hex_tab[7]);
        chk("twolow_mask", 64'(o_mask), 64'h0B);

        // Reset mid-frame discards the partial frame
        for (int i = 0; i < 5; i++) show(i, hex_tab[i], 6);
        chk("pre_rst_mask", 64'(o_mask), 64'h1F);
        valid_cnt = 0;
        cyc(1'b1, '1, 7'b1111111);
        chk("post_rst_mask", 64'(o_mask), 64'h0);
        idle(3);
        chk("post_rst_novalid", 64'(valid_cnt), 64'd0);
        scan(32'hDEADBEEF, -1, 7'h7F, 6);
        chk("rst_scan_valid", 64'(valid_cnt), 64'd1);
        chk("rst_scan_word",  64'(last_word), 64'hDEADBEEF);
        chk("rst_scan_err",   64'(last_err),  64'h0);

        // Random bus activity against the model
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                cyc(1'b1, '1, 7'b1111111);
            end else if (r < 10) begin
                a = ND'($urandom);
                repeat ($urandom_range(1, 5)) cyc(1'b0, a, 7'($urandom));
            end else begin
                d  = $urandom_range(0, ND - 1);
                dw = $urandom_range(1, 8);
                p  = ($urandom_range(0, 11) == 0) ? 7'($urandom)
                                                  : hex_tab[$urandom_range(0, 15)];
                if (r < 20) begin
                    show(d, p, $urandom_range(1, 3));
                    show(d, p ^ 7'b0000100, 1);
                end
                show(d, p, dw);
            end
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_frame_decoder.md
# seg_frame_decoder

Receive-side counterpart to the on-board binary-to-seven-segment encoder. Observes a multiplexed, active-low seven-segment display bus (segment lines plus per-digit anode strobes) and recovers the hexadecimal word being shown. Digits are captured after a stability window, decoded back to 4-bit nibbles, and assembled into one word. Used as an in-design loopback checker for display output and as a bench observer for display drivers.

## Interface
Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (1..8)
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (>=2)

Ports:
- i_clk  in  1  system clock; single clock domain
- i_rst  in  1  synchronous, active-high reset
- i_seg  in  7  segment lines, active-low; bit 6 = g ... bit 0 = a
- i_an  in  NUM_DIGITS  digit strobes, active-low; exactly one low = digit i driven
- o_word  out  4*NUM_DIGITS  last completed frame; digit i in o_word[4i+3:4i]
- o_valid  out  1  one-cycle pulse: o_word/o_err updated with a new frame
- o_err  out  1  frame contained >=1 non-hex segment pattern; valid with o_valid, held until next frame
- o_mask  out  NUM_DIGITS  digits captured so far in the frame in progress

## Operation
- Input stage: i_seg/i_an registered once (r_seg, r_an) every cycle.
- Stability counter cnt: pair {r_an, r_seg} unchanged from previous cycle -> cnt increments (saturates at STABLE_CYCLES); changed -> cnt = 1, clear per-dwell captured flag.
- r_an not one-hot-low (all high = blanking, or >1 low) -> cnt = 0, no capture.
- Capture: cnt == STABLE_CYCLES, r_an one-hot-low at index i, captured flag clear -> write decoded nibble to frame buffer slot i, set mask bit i, set captured flag. Exactly one capture per dwell, however long.
- Decode (active-low, g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. Any other pattern (incl. 1111111 blank) -> nibble 0, set frame-error flag.
- Re-capture of a digit already in the mask before frame completes: overwrite nibble; mask unchanged; an earlier error stays set.
- Frame complete: mask all ones after a capture -> next cycle o_word = frame buffer, o_err = frame-error flag, o_valid = 1; mask and frame-error flag clear in the same cycle. Digits may arrive in any order.
- Reset (any time, incl. mid-frame): all state cleared; partial frame discarded.

## Timing
- Reset values: o_word = 0, o_valid = 0, o_err = 0, o_mask = 0; cnt = 0, captured flag clear.
- Pair first present on inputs in cycle t -> registered t+1 (cnt=1) -> capture in cycle t+STABLE_CYCLES -> o_mask bit visible t+STABLE_CYCLES+1.
- Final digit: o_valid high in cycle t+STABLE_CYCLES+1, exactly one cycle; o_word/o_err change only in that cycle.
- Dwell shorter than STABLE_CYCLES registered cycles: never captured.
- Segment glitch inside a dwell restarts the window; a later stable value is captured once.
- Single-digit configuration (NUM_DIGITS=1): every capture completes a frame.

## Structure
- Shared package seg_pkg: 7-bit active-low pattern constants for 0..F and SEG_BLANK, shared with the encoder so both ends use one table.
- Sub-module seg2bin: combinational, i_seg[6:0] -> o_bin[3:0], o_hit (1 = legal hex pattern); instantiated once on r_seg.
- Top holds input registers, stability counter, captured flag, frame buffer, mask, error flag, output registers.

## Test plan
- Reset then scan digits 0..7 showing 0x12345678 pattern, 6-cycle dwells, STABLE_CYCLES=4 -> one o_valid pulse, o_word = 0x12345678, o_err = 0.
- Digit 3 shows 1111111, others legal -> o_valid with o_err = 1, o_word[15:12] = 0.
- 3-cycle dwell on digit 5 with STABLE_CYCLES=4 -> o_mask[5] stays 0, no o_valid until a 4+ cycle dwell on digit 5.
- Digit 2 held 100 cycles -> captured once (o_mask[2] rises once); no duplicate effect; frame completes normally.
- i_an = all high and i_an with two lows for 10 cycles each -> no capture, o_mask unchanged.
- i_rst pulsed after 5 digits captured -> o_mask = 0, no o_valid; subsequent full scan of 0xDEADBEEF -> o_word = 0xDEADBEEF.
